// File: rtl/spmv_pe_ctrl.sv
// spmv_pe_ctrl: command/control unit for one SpMV processing element.
// Sits on the daisy-chained 64-bit opcode bus and the busy chain. It decodes
// PE-addressed or broadcast commands into a small register file and an
// IDLE/STEADY state machine, and pulses done when the progress register
// catches up with the end register.
// Optional feature: define SPMV_PE_READBACK_EN to let a targeted OP_RD
// replace the forwarded word with an OP_RD_RSP carrying the register value.
module spmv_pe_ctrl #(
  parameter int ID        = 0,
  parameter int PE_ID_W   = 4,
  parameter int NUM_REGS  = 4,
  parameter int REG_IDX_W = 4,
  parameter int REG_W     = 48,
  parameter int CUR_IDX   = 0,
  parameter int END_IDX   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [63:0]               opt_in,
  output logic [63:0]               opt_out,
  input  logic                      busy_in,
  output logic                      busy_out,
  input  logic                      ext_busy,
  input  logic                      progress_inc,
  output logic                      pe_rst,
  output logic                      steady,
  output logic                      done,
  output logic [NUM_REGS*REG_W-1:0] regs_flat
);

  localparam int VAL_LSB = 12 + REG_IDX_W;

  localparam logic [6:0] OP_RST    = 7'd1;
  localparam logic [6:0] OP_STEADY = 7'd2;
  localparam logic [6:0] OP_LD     = 7'd3;
`ifdef SPMV_PE_READBACK_EN
  localparam logic [6:0] OP_RD     = 7'd4;
  localparam logic [6:0] OP_RD_RSP = 7'd5;
`endif

  typedef enum logic {
    IDLE   = 1'b0,
    STEADY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [63:0]       opt_q, opt_d;
  logic [63:0]       opt_out_q, opt_out_d;
  logic              busy_out_q, busy_out_d;
  logic              pe_rst_q, pe_rst_d;
  logic              done_q, done_d;
  logic [REG_W-1:0]  regs_q [NUM_REGS];
  logic [REG_W-1:0]  regs_d [NUM_REGS];

  // Decoded fields of the registered opcode word.
  logic [6:0]           op;
  logic [PE_ID_W-1:0]   pe_id;
  logic                 bcast;
  logic [REG_IDX_W-1:0] idx;
  logic [REG_W-1:0]     val;
  logic                 targeted;
  logic                 idx_valid;

`ifdef SPMV_PE_READBACK_EN
  logic [REG_W-1:0]     rd_val;

  // Build an OP_RD_RSP word for this PE: value, index, own id, not broadcast.
  function automatic logic [63:0] make_rsp(input logic [REG_IDX_W-1:0] r_idx,
                                           input logic [REG_W-1:0]     r_val);
    logic [63:0] w;
    w                    = 64'd0;
    w[6:0]               = OP_RD_RSP;
    w[7 +: PE_ID_W]      = PE_ID_W'(ID);
    w[11]                = 1'b0;
    w[12 +: REG_IDX_W]   = r_idx;
    w[VAL_LSB +: REG_W]  = r_val;
    return w;
  endfunction
`endif

  // Field extraction and address match on the registered opcode.
  always_comb begin
    op        = opt_q[6:0];
    pe_id     = opt_q[7 +: PE_ID_W];
    bcast     = opt_q[11];
    idx       = opt_q[12 +: REG_IDX_W];
    val       = opt_q[VAL_LSB +: REG_W];
    targeted  = bcast | (pe_id == PE_ID_W'(ID));
    idx_valid = ({1'b0, idx} < (REG_IDX_W + 1)'(NUM_REGS));
    opt_d     = opt_in;
  end

`ifdef SPMV_PE_READBACK_EN
  // Select the register addressed by a read request.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == REG_IDX_W'(i)) begin
        rd_val = regs_q[i];
      end else begin
        rd_val = rd_val;
      end
    end
  end
`endif

  // Next-state logic: commands, progress counting, completion, forwarding.
  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    done_d     = 1'b0;
    pe_rst_d   = 1'b0;
    opt_out_d  = opt_q;
    busy_out_d = busy_in | ext_busy | (state_q == STEADY);

    if (targeted && (op == OP_RST)) begin
      // Local reset wipes everything and returns to IDLE without a done pulse.
      pe_rst_d = 1'b1;
      state_d  = IDLE;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = '0;
      end
    end else begin
      if ((state_q == STEADY) && progress_inc) begin
        regs_d[CUR_IDX] = regs_q[CUR_IDX] + REG_W'(1);
      end else begin
        regs_d[CUR_IDX] = regs_q[CUR_IDX];
      end

      // A load comes after the increment so a load of CUR overrides it.
      if (targeted && (op == OP_LD) && idx_valid) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (idx == REG_IDX_W'(i)) begin
            regs_d[i] = val;
          end else begin
            regs_d[i] = regs_d[i];
          end
        end
      end else begin
        regs_d = regs_d;
      end

      case (state_q)
        IDLE: begin
          if (targeted && (op == OP_STEADY)) begin
            state_d = STEADY;
          end else begin
            state_d = IDLE;
          end
        end
        STEADY: begin
          if ((regs_q[CUR_IDX] == regs_q[END_IDX]) && !ext_busy) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = STEADY;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

`ifdef SPMV_PE_READBACK_EN
    if ((op == OP_RD) && !bcast && (pe_id == PE_ID_W'(ID)) && idx_valid) begin
      opt_out_d = make_rsp(idx, rd_val);
    end else begin
      opt_out_d = opt_q;
    end
`endif
  end

  // State, register file and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opt_q      <= 64'd0;
      opt_out_q  <= 64'd0;
      busy_out_q <= 1'b0;
      pe_rst_q   <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      opt_q      <= opt_d;
      opt_out_q  <= opt_out_d;
      busy_out_q <= busy_out_d;
      pe_rst_q   <= pe_rst_d;
      done_q     <= done_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*REG_W +: REG_W] = regs_q[g];
  end

  assign opt_out  = opt_out_q;
  assign busy_out = busy_out_q;
  assign pe_rst   = pe_rst_q;
  assign done     = done_q;
  assign steady   = (state_q == STEADY);

endmodule

// File: tb/tb_spmv_pe_ctrl.sv
// Self-checking bench for spmv_pe_ctrl (ID=2, 4 registers of 48 bits).
// Expected forwarded words are queued when stimulus is driven and popped
// when the word leaves the PE two cycles later.
module tb_spmv_pe_ctrl;

  localparam logic [6:0] OP_NOP    = 7'd0;
  localparam logic [6:0] OP_RST    = 7'd1;
  localparam logic [6:0] OP_STEADY = 7'd2;
  localparam logic [6:0] OP_LD     = 7'd3;
  localparam logic [6:0] OP_RD     = 7'd4;
  localparam logic [6:0] OP_RD_RSP = 7'd5;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  opt_in;
  logic [63:0]  opt_out;
  logic         busy_in, busy_out, ext_busy, progress_inc;
  logic         pe_rst, steady, done;
  logic [191:0] regs_flat;

  logic [63:0]  exp_q [$];
  int           n_checks = 0;
  int           n_fail   = 0;

  spmv_pe_ctrl #(.ID(2), .PE_ID_W(4), .NUM_REGS(4), .REG_IDX_W(4), .REG_W(48),
                 .CUR_IDX(0), .END_IDX(1)) dut (
    .clk(clk), .rst(rst), .opt_in(opt_in), .opt_out(opt_out),
    .busy_in(busy_in), .busy_out(busy_out), .ext_busy(ext_busy),
    .progress_inc(progress_inc), .pe_rst(pe_rst), .steady(steady),
    .done(done), .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [6:0] op, input logic [3:0] pe,
                                     input logic bc, input logic [3:0] idx,
                                     input logic [47:0] val);
    return {val, idx, bc, pe, op};
  endfunction

  function automatic logic [47:0] rg(input int i);
    return regs_flat[i*48 +: 48];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for a cycle, then idle until it has taken effect.
  task automatic drive(input logic [63:0] w);
    opt_in = w;
    tick();
    opt_in = 64'd0;
    tick();
  endtask

  task automatic test_reset();
    logic [63:0] e;
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (opt_out !== 64'd0) begin n_fail++; $display("FAIL reset_opt_out got=%h exp=0", opt_out); end
    n_checks++; if ({busy_out, steady, done, pe_rst} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {busy_out, steady, done, pe_rst}); end
    n_checks++; if (regs_flat !== 192'd0) begin n_fail++; $display("FAIL reset_regs got=%h exp=0", regs_flat); end
    rst = 1'b0;
    tick();
    e = 64'd0;
    n_checks++; if (opt_out !== e) begin n_fail++; $display("FAIL reset_idle_out got=%h exp=%h", opt_out, e); end
  endtask

  task automatic test_load();
    logic [63:0] w, e;
    w = mk(OP_LD, 4'd2, 1'b0, 4'd1, 48'h10);
    exp_q.push_back(w);
    opt_in = w;
    tick();
    n_checks++; if (rg(1) !== 48'h0) begin n_fail++; $display("FAIL load_early got=%h exp=0", rg(1)); end
    opt_in = 64'd0;
    tick();
    n_checks++; if (rg(1) !== 48'h10) begin n_fail++; $display("FAIL load_reg1 got=%h exp=10", rg(1)); end
    e = exp_q.pop_front();
    n_checks++; if (opt_out !== e) begin n_fail++; $display("FAIL load_fwd got=%h exp=%h", opt_out, e); end
    w = mk(OP_LD, 4'd3, 1'b0, 4'd1, 48'h77);
    exp_q.push_back(w);
    drive(w);
    n_checks++; if (rg(1) !== 48'h10) begin n_fail++; $display("FAIL load_other_pe got=%h exp=10", rg(1)); end
    e = exp_q.pop_front();
    n_checks++; if (opt_out !== e) begin n_fail++; $display("FAIL load_other_fwd got=%h exp=%h", opt_out, e); end
  endtask

  task automatic test_broadcast();
    logic [63:0]  w, e;
    logic [191:0] snap;
    w = mk(OP_LD, 4'd5, 1'b1, 4'd0, 48'hABC);
    exp_q.push_back(w);
    drive(w);
    n_checks++; if (rg(0) !== 48'hABC) begin n_fail++; $display("FAIL bcast_reg0 got=%h exp=abc", rg(0)); end
    e = exp_q.pop_front();
    n_checks++; if (opt_out !== e) begin n_fail++; $display("FAIL bcast_fwd got=%h exp=%h", opt_out, e); end
    snap = regs_flat;
    drive(mk(OP_LD, 4'd5, 1'b1, 4'd9, 48'hDEAD));
    n_checks++; if (regs_flat !== snap) begin n_fail++; $display("FAIL bcast_bad_idx got=%h exp=%h", regs_flat, snap); end
  endtask

  task automatic test_progress();
    drive(mk(OP_LD, 4'd2, 1'b0, 4'd0, 48'd0));
    drive(mk(OP_LD, 4'd2, 1'b0, 4'd1, 48'd3));
    drive(mk(OP_STEADY, 4'd2, 1'b0, 4'd0, 48'd0));
    n_checks++; if (steady !== 1'b1) begin n_fail++; $display("FAIL prog_steady got=%b exp=1", steady); end
    tick();
    n_checks++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL prog_busy got=%b exp=1", busy_out); end
    progress_inc = 1'b1;
    repeat (3) tick();
    progress_inc = 1'b0;
    n_checks++; if ({rg(0), steady, done} !== {48'd3, 1'b1, 1'b0}) begin n_fail++; $display("FAIL prog_count got=%h/%b/%b exp=3/1/0", rg(0), steady, done); end
    tick();
    n_checks++; if ({done, steady, busy_out} !== 3'b101) begin n_fail++; $display("FAIL prog_done got=%b exp=101", {done, steady, busy_out}); end
    tick();
    n_checks++; if ({done, busy_out} !== 2'b00) begin n_fail++; $display("FAIL prog_after got=%b exp=00", {done, busy_out}); end
  endtask

  task automatic test_ext_busy();
    drive(mk(OP_LD, 4'd2, 1'b0, 4'd0, 48'd5));
    drive(mk(OP_LD, 4'd2, 1'b0, 4'd1, 48'd5));
    ext_busy = 1'b1;
    drive(mk(OP_STEADY, 4'd2, 1'b0, 4'd0, 48'd0));
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({steady, done} !== 2'b10) begin n_fail++; $display("FAIL xbusy_hold got=%b exp=10", {steady, done}); end
    end
    ext_busy = 1'b0;
    tick();
    n_checks++; if ({steady, done} !== 2'b01) begin n_fail++; $display("FAIL xbusy_done got=%b exp=01", {steady, done}); end
    tick();
    n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL xbusy_drop got=%b exp=0", busy_out); end
    busy_in = 1'b1;
    tick();
    n_checks++; if ({busy_out, steady} !== 2'b10) begin n_fail++; $display("FAIL busy_in_idle got=%b exp=10", {busy_out, steady}); end
    busy_in = 1'b0;
    tick();
    n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL busy_in_release got=%b exp=0", busy_out); end
  endtask

  task automatic test_ld_wins();
    drive(mk(OP_LD, 4'd2, 1'b0, 4'd0, 48'd0));
    drive(mk(OP_LD, 4'd2, 1'b0, 4'd1, 48'd100));
    drive(mk(OP_STEADY, 4'd2, 1'b0, 4'd0, 48'd0));
    progress_inc = 1'b1;
    drive(mk(OP_LD, 4'd2, 1'b0, 4'd0, 48'd50));
    progress_inc = 1'b0;
    n_checks++; if (rg(0) !== 48'd50) begin n_fail++; $display("FAIL ld_wins got=%0d exp=50", rg(0)); end
  endtask

  task automatic test_op_rst();
    logic [63:0] w, e;
    drive(mk(OP_LD, 4'd2, 1'b0, 4'd2, 48'h123));
    n_checks++; if ({steady, rg(2)} !== {1'b1, 48'h123}) begin n_fail++; $display("FAIL rst_pre got=%b/%h exp=1/123", steady, rg(2)); end
    w = mk(OP_RST, 4'd2, 1'b0, 4'd0, 48'd0);
    exp_q.push_back(w);
    opt_in = w;
    tick();
    n_checks++; if (pe_rst !== 1'b0) begin n_fail++; $display("FAIL oprst_early got=%b exp=0", pe_rst); end
    opt_in = 64'd0;
    tick();
    n_checks++; if ({pe_rst, steady, done} !== 3'b100) begin n_fail++; $display("FAIL oprst_pulse got=%b exp=100", {pe_rst, steady, done}); end
    n_checks++; if (regs_flat !== 192'd0) begin n_fail++; $display("FAIL oprst_regs got=%h exp=0", regs_flat); end
    e = exp_q.pop_front();
    n_checks++; if (opt_out !== e) begin n_fail++; $display("FAIL oprst_fwd got=%h exp=%h", opt_out, e); end
    tick();
    n_checks++; if ({pe_rst, done} !== 2'b00) begin n_fail++; $display("FAIL oprst_after got=%b exp=00", {pe_rst, done}); end

    drive(mk(OP_LD, 4'd2, 1'b0, 4'd0, 48'd7));
    drive(mk(OP_LD, 4'd2, 1'b0, 4'd1, 48'd9));
    drive(mk(OP_STEADY, 4'd2, 1'b0, 4'd0, 48'd0));
    opt_in = mk(OP_LD, 4'd7, 1'b0, 4'd3, 48'h99);
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (opt_out !== 64'd0) begin n_fail++; $display("FAIL xrst_opt_out got=%h exp=0", opt_out); end
    n_checks++; if ({busy_out, steady, done, pe_rst} !== 4'b0000) begin n_fail++; $display("FAIL xrst_flags got=%b exp=0000", {busy_out, steady, done, pe_rst}); end
    n_checks++; if (regs_flat !== 192'd0) begin n_fail++; $display("FAIL xrst_regs got=%h exp=0", regs_flat); end
    rst = 1'b0;
    opt_in = 64'd0;
    tick();
    n_checks++; if ({done, steady} !== 2'b00) begin n_fail++; $display("FAIL xrst_after got=%b exp=00", {done, steady}); end
  endtask

  task automatic test_unknown_and_rd();
    logic [63:0]  w, e;
    logic [191:0] snap;
    snap = regs_flat;
    w = mk(7'h7F, 4'd2, 1'b0, 4'd0, 48'h1234);
    exp_q.push_back(w);
    drive(w);
    e = exp_q.pop_front();
    n_checks++; if (opt_out !== e) begin n_fail++; $display("FAIL unknown_fwd got=%h exp=%h", opt_out, e); end
    n_checks++; if (regs_flat !== snap) begin n_fail++; $display("FAIL unknown_regs got=%h exp=%h", regs_flat, snap); end

    drive(mk(OP_LD, 4'd2, 1'b0, 4'd1, 48'h55));
    w = mk(OP_RD, 4'd2, 1'b0, 4'd1, 48'd0);
`ifdef SPMV_PE_READBACK_EN
    exp_q.push_back(mk(OP_RD_RSP, 4'd2, 1'b0, 4'd1, 48'h55));
`else
    exp_q.push_back(w);
`endif
    drive(w);
    e = exp_q.pop_front();
    n_checks++; if (opt_out !== e) begin n_fail++; $display("FAIL rd_targeted got=%h exp=%h", opt_out, e); end

    w = mk(OP_RD, 4'd2, 1'b1, 4'd1, 48'd0);
    exp_q.push_back(w);
    drive(w);
    e = exp_q.pop_front();
    n_checks++; if (opt_out !== e) begin n_fail++; $display("FAIL rd_bcast got=%h exp=%h", opt_out, e); end

    w = mk(OP_RD, 4'd2, 1'b0, 4'd9, 48'd0);
    exp_q.push_back(w);
    drive(w);
    e = exp_q.pop_front();
    n_checks++; if (opt_out !== e) begin n_fail++; $display("FAIL rd_bad_idx got=%h exp=%h", opt_out, e); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w, e;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        w = mk(OP_LD, 4'd6, 1'b1, 4'(k), 48'h100 + 48'(k));
      end else begin
        w = mk(OP_NOP, 4'd0, 1'b0, 4'd0, 48'd0);
      end
      exp_q.push_back(w);
      opt_in = w;
      tick();
      if (k >= 1) begin
        e = exp_q.pop_front();
        n_checks++; if (opt_out !== e) begin n_fail++; $display("FAIL b2b_fwd_%0d got=%h exp=%h", k, opt_out, e); end
      end
    end
    opt_in = 64'd0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rg(i) !== 48'h100 + 48'(i)) begin n_fail++; $display("FAIL b2b_reg_%0d got=%h exp=%h", i, rg(i), 48'h100 + 48'(i)); end
    end
  endtask

  initial begin
    rst          = 1'b1;
    opt_in       = 64'd0;
    busy_in      = 1'b0;
    ext_busy     = 1'b0;
    progress_inc = 1'b0;
    test_reset();
    test_load();
    test_broadcast();
    test_progress();
    test_ext_busy();
    test_ld_wins();
    test_op_rst();
    test_unknown_and_rd();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spmv_pe_ctrl.md
Name: spmv_pe_ctrl

Overview:
- Parametrised command/control unit for an SpMV processing element.
- Sits on the daisy-chained 64-bit opcode bus and the busy chain. Decodes PE-addressed and broadcast commands into a generic register file and an IDLE/STEADY state machine.
- Tracks work progress against a stored end value and raises done.
- Generalises the fixed 4x48-bit PE control to N registers of configurable width, plus progress counting and optional register readback.

Parameters:
- ID, 0, this PE's index on the opcode bus.
- PE_ID_W, 4, width of the PE-select field.
- NUM_REGS, 4, number of loadable registers (2..16).
- REG_IDX_W, 4, width of the register-index field.
- REG_W, 48, register width, max 64-12-REG_IDX_W.
- CUR_IDX, 0, index of the progress (current) register.
- END_IDX, 1, index of the end/limit register.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- opt_in  in  64  opcode from upstream PE
- opt_out  out  64  opcode to downstream PE
- busy_in  in  1  busy from downstream chain
- busy_out  out  1  aggregated busy to upstream
- ext_busy  in  1  busy from PE datapath (decoder, caches)
- progress_inc  in  1  datapath completed one unit; increment CUR register
- pe_rst  out  1  one-cycle local reset pulse to PE datapath
- steady  out  1  state==STEADY
- done  out  1  one-cycle pulse on STEADY->IDLE
- regs_flat  out  NUM_REGS*REG_W  all registers, reg i at [i*REG_W +: REG_W]

Behaviour:
- Opcode field layout:
  - opt[6:0] opcode.
  - opt[7 +: PE_ID_W] PE id.
  - opt[11] broadcast.
  - opt[12 +: REG_IDX_W] register index.
  - opt[63 : 12+REG_IDX_W] value, zero-extended/truncated to REG_W.
- Opcode values: OP_NOP=0, OP_RST=1, OP_STEADY=2, OP_LD=3, OP_RD=4, OP_RD_RSP=5.
- Targeted = broadcast bit set, or PE id field == ID.
- Pipeline:
  - opt_in is registered into opt_r; decode acts on opt_r.
  - opt_out <= opt_r, so chain latency is 2 cycles per PE.
  - Register/state effects are visible 2 cycles after opt_in.
- OP_RST (targeted):
  - pe_rst=1 for exactly the following cycle.
  - All registers cleared to 0; state -> IDLE; no done pulse.
- OP_STEADY (targeted), from IDLE: state -> STEADY. Ignored in STEADY.
- OP_LD (targeted):
  - registers[idx] <= value.
  - idx >= NUM_REGS is silently ignored.
  - Allowed in either state.
- Progress counting:
  - progress_inc while STEADY: registers[CUR_IDX] += 1, wrapping modulo 2^REG_W.
  - Ignored in IDLE.
  - If OP_LD writes CUR_IDX in the same cycle as progress_inc, LD wins and the increment is lost.
- Completion:
  - In STEADY, when registers[CUR_IDX]==registers[END_IDX] and ext_busy==0: state -> IDLE and done pulses 1 cycle.
  - CUR==END at STEADY entry exits on the next evaluated cycle.
- busy_out <= busy_in | ext_busy | (state==STEADY), registered.
- Untargeted and unknown opcodes: forwarded unchanged, no local effect.
- rst (synchronous): opt_r, opt_out, registers, busy_out, pe_rst and done all go to 0; state=IDLE. This holds mid-STEADY: done does not pulse.

Optional Feature:
- Macro: SPMV_PE_READBACK_EN.
- Enabled: a targeted, non-broadcast OP_RD with valid idx replaces the forwarded word. opt_out <= {registers[idx] zero-extended, idx, ID, broadcast=0, OP_RD_RSP}.
- Enabled, broadcast or invalid idx: OP_RD forwards unchanged.
- Disabled: OP_RD is treated as an unknown opcode and forwarded unchanged.

Test Plan:
- ID=2; OP_LD pe=2 idx=1 value=0x10 -> registers[1]==0x10 two cycles after opt_in; opt_out equals input word 2 cycles later. Same word with pe=3 -> no change.
- Broadcast OP_LD idx=0 value=0xABC -> registers[0]==0xABC regardless of ID. idx=9 with NUM_REGS=4 -> no register changes.
- Load CUR=0, END=3; OP_STEADY -> steady=1, busy_out=1. Three progress_inc pulses -> done pulses once, steady=0, busy_out falls next cycle with busy_in=0 and ext_busy=0.
- CUR==END reached while ext_busy=1 -> stays STEADY until ext_busy=0, then done. busy_in=1 alone -> busy_out=1 in IDLE.
- OP_RST mid-STEADY -> pe_rst pulses one cycle, registers all 0, state IDLE, no done. Repeat using external rst -> same outcome, opt_out=0.
- SPMV_PE_READBACK_EN, registers[1]=0x55, OP_RD pe=ID idx=1 -> opt_out opcode=5, value field=0x55. Without the macro -> opt_out equals the OP_RD word.
